ram_arbiter: RTL and testbench

//  Shares one single-port RAM (negedge-clocked, read-or-write per cycle) between NumReq requesters
//  (core data port, debug/loader port). Round-robin grant, valid/ready request handshake, one-cycle

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/ram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// ram_arb_pkg
// Shared types and helpers for the single-port RAM arbiter:
//   ram_arb_state_e : FSM states (IDLE, ISSUE, RESP)
//   idx_width()     : width of a requester index (never below 1 bit)
// -----------------------------------------------------------------------------
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } ram_arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted valid bit at or after
// ptr, wrapping from NumReq-1 back to 0.
// Ports:
//   valid     in  NumReq  request vector
//   ptr       in  IdxW    highest-priority position this cycle
//   grant     out NumReq  one-hot winner (all zero when nothing is valid)
//   grant_idx out IdxW    index of the winner (0 when nothing is valid)
//   any_valid out 1       at least one request pending
// -----------------------------------------------------------------------------
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NumReq = 2,
  localparam int IdxW = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] valid,
  input  logic [IdxW-1:0]   ptr,
  output logic [NumReq-1:0] grant,
  output logic [IdxW-1:0]   grant_idx,
  output logic              any_valid
);

  logic            found;
  logic [IdxW-1:0] cand;

  // NOTE: every signal written here gets a default before the loop, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NumReq; k++) begin
      // Walk ptr, ptr+1, ... modulo NumReq without a divider.
      if (int'(ptr) + k >= NumReq) cand = IdxW'(int'(ptr) + k - NumReq);
      else                         cand = IdxW'(int'(ptr) + k);
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign any_valid = |valid;

endmodule

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
// Shares one negedge-clocked single-port RAM between NumReq requesters.
// Round-robin accept, one op in flight, one-cycle response pulse.
// Flow: accept (IDLE/RESP) -> ISSUE (RAM strobe, RAM acts mid-cycle)
//       -> RESP (rsp_* visible for exactly one cycle, may accept again).
// Ports:
//   clk, reset              clock (posedge), synchronous active-high reset
//   req_valid/ready         per-port handshake, ready is one-hot
//   req_write/addr/wdata    per-port op, addr/wdata packed per port
//   rsp_valid               one-cycle pulse to the owner of the finished op
//   rsp_err, rsp_rdata      out-of-range flag, read data (0 for writes/errors)
//   ram_read/write/addr/wdata/rdata   RAM-side interface
// -----------------------------------------------------------------------------
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int Width     = 32,
  parameter int Depth     = 32,
  parameter int AddrWidth = 30,
  parameter int NumReq    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NumReq-1:0]           req_valid,
  output logic [NumReq-1:0]           req_ready,
  input  logic [NumReq-1:0]           req_write,
  input  logic [NumReq*AddrWidth-1:0] req_addr,
  input  logic [NumReq*Width-1:0]     req_wdata,
  output logic [NumReq-1:0]           rsp_valid,
  output logic                        rsp_err,
  output logic [Width-1:0]            rsp_rdata,
  output logic                        ram_read,
  output logic                        ram_write,
  output logic [AddrWidth-1:0]        ram_addr,
  output logic [Width-1:0]            ram_wdata,
  input  logic [Width-1:0]            ram_rdata
);

  localparam int IdxW = idx_width(NumReq);
  localparam logic [AddrWidth-1:0] DepthA = AddrWidth'(Depth);

  typedef struct packed {
    logic [IdxW-1:0]      owner;
    logic                 write;
    logic [AddrWidth-1:0] addr;
    logic [Width-1:0]     wdata;
  } op_t;

  ram_arb_state_e    state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  op_t               op_q, op_d;
  logic [NumReq-1:0] rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [Width-1:0]  rsp_rdata_q, rsp_rdata_d;

  logic [NumReq-1:0]    grant;
  logic [IdxW-1:0]      grant_idx;
  logic                 any_valid;
  logic                 win_write;
  logic [AddrWidth-1:0] win_addr;
  logic [Width-1:0]     win_wdata;
  logic                 can_accept;
  logic                 op_in_range;
  logic                 issue_live;

  rr_arbiter #(.NumReq(NumReq)) u_rr (
    .valid     (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  // One-hot mux of the winning port's request fields.
  always_comb begin
    win_write = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant[i]) begin
        win_write = req_write[i];
        win_addr  = req_addr[i*AddrWidth +: AddrWidth];
        win_wdata = req_wdata[i*Width +: Width];
      end
    end
  end

  assign can_accept  = (state_q == IDLE) || (state_q == RESP);
  assign op_in_range = (op_q.addr < DepthA);
  // Gating with reset drops the strobes in the same cycle reset is raised,
  // so an interrupted op never reaches the RAM at its negedge.
  assign issue_live  = (state_q == ISSUE) && op_in_range && !reset;

  assign req_ready = (can_accept && !reset) ? grant : '0;
  assign ram_read  = issue_live && !op_q.write;
  assign ram_write = issue_live && op_q.write;
  // Address/data simply follow the op latch; the strobes alone qualify them.
  assign ram_addr  = op_q.addr;
  assign ram_wdata = op_q.wdata;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  // Response registers default to zero, which is what clears them after RESP.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_d        = op_q;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE, RESP: begin
        if (any_valid) begin
          op_d.owner = grant_idx;
          op_d.write = win_write;
          op_d.addr  = win_addr;
          op_d.wdata = win_wdata;
          ptr_d      = (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + IdxW'(1);
          state_d    = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // The RAM has already acted at the mid-cycle negedge, so ram_rdata
        // holds the word for this op by the closing posedge.
        rsp_valid_d[op_q.owner] = 1'b1;
        rsp_err_d               = !op_in_range;
        rsp_rdata_d             = (!op_q.write && op_in_range) ? ram_rdata : '0;
        state_d                 = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge value
  // of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      // NOTE: the op latch is datapath but is still reset, because it drives
      // ram_addr/ram_wdata, which must read 0 coming out of reset.
      op_q        <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
// Pairs ram_arbiter with a negedge-clocked RAM model. A per-cycle monitor keeps
// a transaction-level reference (round-robin rule, busy window, reference
// memory, expected issue/response cycles) and compares every cycle. Directed
// table vectors, hand sequences and a random phase drive the stimulus.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 30;
  localparam int NR = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_write = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*W-1:0]  req_wdata = '0;
  logic [NR-1:0]    rsp_valid;
  logic             rsp_err;
  logic [W-1:0]     rsp_rdata;
  logic             ram_read;
  logic             ram_write;
  logic [AW-1:0]    ram_addr;
  logic [W-1:0]     ram_wdata;
  logic [W-1:0]     ram_rdata = '0;

  always #5 clk = ~clk;

  ram_arbiter #(.Width(W), .Depth(D), .AddrWidth(AW), .NumReq(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .ram_read  (ram_read),
    .ram_write (ram_write),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Single-port RAM: acts on negedge, read or write per cycle.
  logic [W-1:0] mem [D];
  always @(negedge clk) begin
    if (ram_write && ram_addr < AW'(D)) mem[ram_addr[4:0]] <= ram_wdata;
    if (ram_read && ram_addr < AW'(D))  ram_rdata <= mem[ram_addr[4:0]];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model / monitor
  // ---------------------------------------------------------------------------
  typedef struct {
    int           port;
    bit           write;
    logic [AW-1:0] addr;
    logic [W-1:0] wdata;
    bit           err;
    logic [W-1:0] rdata;
    int           issue_cyc;
    int           rsp_cyc;
  } exp_op_t;

  exp_op_t      pend[$];
  logic [W-1:0] ref_mem [D];
  int           cyc = 0;
  int           m_ptr = 0;
  int           last_acc = -100;
  bit           mon_en = 1'b0;
  int           acc_cnt [NR];
  int           acc_total = 0;
  int           rsp_pulses = 0;
  logic [NR-1:0] acc_last = '0;
  int           grant_log[$];

  always @(negedge clk) begin : mon
    logic [NR-1:0] exp_ready, exp_rv;
    logic          exp_rd, exp_wr, exp_err;
    logic [W-1:0]  exp_rdata;
    exp_op_t       e;
    int            q;
    if (mon_en) begin
      cyc++;
      if (|rsp_valid) rsp_pulses++;
      check("ram_rd_wr_excl", 64'(ram_read & ram_write), 64'(0));
      check("ready_onehot", 64'($countones(req_ready) <= 1), 64'(1));
      check("rsp_onehot", 64'($countones(rsp_valid) <= 1), 64'(1));
      if (reset) begin
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_strobes", 64'({ram_read, ram_write}), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        pend.delete();
        m_ptr    = 0;
        last_acc = -100;
        acc_last = '0;
      end else begin
        // RAM strobes: only in the cycle right after an in-range accept.
        exp_rd = 1'b0;
        exp_wr = 1'b0;
        foreach (pend[i]) begin
          if (pend[i].issue_cyc == cyc && !pend[i].err) begin
            exp_rd = !pend[i].write;
            exp_wr = pend[i].write;
            check("ram_addr", 64'(ram_addr), 64'(pend[i].addr));
            if (pend[i].write) check("ram_wdata", 64'(ram_wdata), 64'(pend[i].wdata));
          end
        end
        check("ram_read", 64'(ram_read), 64'(exp_rd));
        check("ram_write", 64'(ram_write), 64'(exp_wr));

        // Response: exactly one cycle, two cycles after the accept cycle.
        exp_rv    = '0;
        exp_err   = 1'b0;
        exp_rdata = '0;
        if (pend.size() > 0 && pend[0].rsp_cyc == cyc) begin
          exp_rv[pend[0].port] = 1'b1;
          exp_err   = pend[0].err;
          exp_rdata = pend[0].rdata;
          void'(pend.pop_front());
        end
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        check("rsp_err", 64'(rsp_err), 64'(exp_err));
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));

        // Accept rule: free unless an op was accepted in the previous cycle;
        // winner is the first valid port at or after the pointer.
        exp_ready = '0;
        if (cyc != last_acc + 1) begin
          for (int k = 0; k < NR; k++) begin
            q = (m_ptr + k) % NR;
            if (req_valid[q] && exp_ready == '0) exp_ready[q] = 1'b1;
          end
        end
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        acc_last = req_valid & exp_ready;

        for (int p = 0; p < NR; p++) begin
          if (acc_last[p]) begin
            e.port      = p;
            e.write     = req_write[p];
            e.addr      = req_addr[p*AW +: AW];
            e.wdata     = req_wdata[p*W +: W];
            e.err       = (e.addr >= AW'(D));
            e.rdata     = (!e.write && !e.err) ? ref_mem[e.addr[4:0]] : '0;
            e.issue_cyc = cyc + 1;
            e.rsp_cyc   = cyc + 2;
            if (e.write && !e.err) ref_mem[e.addr[4:0]] = e.wdata;
            pend.push_back(e);
            last_acc = cyc;
            m_ptr    = (p + 1) % NR;
            acc_cnt[p]++;
            acc_total++;
            grant_log.push_back(p);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    int            port;
    bit            write;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    bit            exp_err;
    logic [W-1:0]  exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic set_port(input int p, input bit v, input bit wr,
                          input logic [AW-1:0] a, input logic [W-1:0] wd);
    req_valid[p]          = v;
    req_write[p]          = wr;
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*W +: W]   = wd;
  endtask

  task automatic do_op(input vec_t v, input string tag);
    bit seen;
    int lat;
    logic [NR-1:0] rv;
    logic          er;
    logic [W-1:0]  rd;
    seen = 1'b0;
    lat  = 0;
    rv   = '0;
    er   = 1'b0;
    rd   = '0;
    @(posedge clk); #1;
    set_port(v.port, 1'b1, v.write, v.addr, v.wdata);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (req_ready[v.port]) seen = 1'b1;
    end
    check({tag, "_accepted"}, 64'(seen), 64'(1));
    @(posedge clk); #1;
    req_valid[v.port] = 1'b0;
    if (seen) begin
      for (int i = 1; i <= 8 && lat == 0; i++) begin
        @(negedge clk);
        if (|rsp_valid) begin
          lat = i;
          rv  = rsp_valid;
          er  = rsp_err;
          rd  = rsp_rdata;
        end
      end
      check({tag, "_latency"}, 64'(lat), 64'(2));
      check({tag, "_port"}, 64'(rv), 64'(1 << v.port));
      check({tag, "_err"}, 64'(er), 64'(v.exp_err));
      check({tag, "_rdata"}, 64'(rd), 64'(v.exp_rdata));
      @(negedge clk);
      check({tag, "_one_cycle"}, 64'(rsp_valid), 64'(0));
    end
  endtask

  initial begin
    int snap0, snap1, snapp, target, guard;
    for (int i = 0; i < D; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    for (int p = 0; p < NR; p++) acc_cnt[p] = 0;

    //              port wr addr   wdata         err rdata
    vecs[0] = '{0, 1, 30'd5,  32'hDEAD_BEEF, 0, 32'h0};
    vecs[1] = '{1, 0, 30'd5,  32'h0,         0, 32'hDEAD_BEEF};
    vecs[2] = '{1, 0, 30'd40, 32'h0,         1, 32'h0};
    vecs[3] = '{0, 1, 30'd31, 32'hA5A5_5A5A, 0, 32'h0};
    vecs[4] = '{1, 0, 30'd31, 32'h0,         0, 32'hA5A5_5A5A};
    vecs[5] = '{0, 0, 30'd32, 32'h0,         1, 32'h0};
    vecs[6] = '{1, 1, 30'd0,  32'h1234_5678, 0, 32'h0};
    vecs[7] = '{0, 0, 30'd0,  32'h0,         0, 32'h1234_5678};
    vecs[8] = '{0, 1, 30'd40, 32'hFFFF_FFFF, 1, 32'h0};
    vecs[9] = '{1, 0, 30'd5,  32'h0,         0, 32'hDEAD_BEEF};

    // Reset, then ten idle cycles with everything at zero.
    reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", 64'(req_ready), 64'(0));
      check("idle_strobes", 64'({ram_read, ram_write}), 64'(0));
      check("idle_rsp", 64'({rsp_valid, rsp_err}), 64'(0));
      check("idle_rdata", 64'(rsp_rdata), 64'(0));
      check("idle_ram_addr", 64'(ram_addr), 64'(0));
      check("idle_ram_wdata", 64'(ram_wdata), 64'(0));
    end

    // Table-driven single ops.
    for (int i = 0; i < 10; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Reset raised during ISSUE: strobes drop at once, no response ever.
    @(posedge clk); #1;
    set_port(0, 1'b1, 1'b0, 30'd3, 32'h0);
    guard = 0;
    while (!req_ready[0] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("rst_issue_accepted", 64'(req_ready[0]), 64'(1));
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    reset = 1'b1;
    snapp = rsp_pulses;
    @(negedge clk);
    check("rst_issue_no_read", 64'(ram_read), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_issue_no_rsp", 64'(rsp_pulses - snapp), 64'(0));

    // Both ports continuously valid: alternating grants, one op per 2 cycles.
    @(posedge clk); #1;
    snap0 = acc_cnt[0];
    snap1 = acc_cnt[1];
    grant_log.delete();
    set_port(0, 1'b1, 1'b0, 30'd1, 32'h0);
    set_port(1, 1'b1, 1'b0, 30'd2, 32'h0);
    repeat (16) @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    check("both_p0_grants", 64'(acc_cnt[0] - snap0), 64'(4));
    check("both_p1_grants", 64'(acc_cnt[1] - snap1), 64'(4));
    for (int i = 1; i < grant_log.size(); i++)
      check("both_alternate", 64'(grant_log[i] != grant_log[i-1]), 64'(1));
    repeat (4) @(negedge clk);

    // Random mix: 2000 accepted ops, checked cycle by cycle by the monitor.
    target = acc_total + 2000;
    guard  = 0;
    while (acc_total < target && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
      for (int p = 0; p < NR; p++) begin
        if (acc_last[p]) req_valid[p] = 1'b0;
        if (!req_valid[p]) begin
          if ($urandom_range(0, 2) == 0)
            set_port(p, 1'b1, 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 39)), W'($urandom));
        end else if (!acc_last[p] && $urandom_range(0, 19) == 0) begin
          req_valid[p] = 1'b0;
        end
      end
    end
    check("random_ops_done", 64'(acc_total >= target), 64'(1));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (5) @(negedge clk);
    check("all_rsp_seen", 64'(pend.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
